serial_cmd_ctrl: RTL and testbench

Byte-level command controller that sits between `serial_rx`/`serial_tx` and the board's control register file. It consumes the received byte stream and parses framed read/write commands. It sequences single-cycle register accesses and schedules read responses back onto the transmitter. Malformed or stalled frames are discarded and counted so the host link always resynchronises on the next sync byte.

---
 rtl/serial_cmd_pkg.sv | 19 +
 rtl/serial_cmd_timeout.sv | 30 +++
 rtl/serial_cmd_ctrl.sv | 176 +++++++++++++++++
 tb/tb_serial_cmd_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmd_pkg.sv
// Shared types and constants for the serial command controller.
package serial_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_DATA    = 3'd2,
    ST_CHK     = 3'd3,
    ST_EXEC    = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_RESP    = 3'd6
  } state_t;

  localparam int CMD_WR_BIT   = 7;
  localparam int CMD_ADDR_MSB = 3;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/serial_cmd_timeout.sv
// Inter-byte watchdog: reloads on clr, counts down while enabled, and raises
// expire while enabled at zero.
module serial_cmd_timeout #(
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= LOAD_VAL;
    end else if (clr) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/serial_cmd_ctrl.sv
// Framed read/write command parser between the serial link and the register file.
// Define SERIAL_CMD_CHECKSUM_EN to require the trailing CHK byte on every frame.
module serial_cmd_ctrl
  import serial_cmd_pkg::*;
#(
  parameter int         TIMEOUT_CLKS = 50000,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_new_data,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_wr_data,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rd_data,
  output logic [7:0] tx_data,
  output logic       tx_new_data,
  input  logic       tx_busy,
  output logic [7:0] err_cnt
);

  function automatic logic [7:0] err_sat_inc(input logic [7:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 8'd1;
  endfunction

  state_t state, state_nxt;

  logic cmd_wr;
  logic wr_nxt;
  logic lat_cmd;
  logic lat_data;
  logic cap_rd;
  logic err_inc;
  logic tmo_en;
  logic tmo_clr;
  logic tmo_exp;

`ifdef SERIAL_CMD_CHECKSUM_EN
  logic [7:0] chk_acc;
`endif

  assign tmo_en  = (state == ST_CMD) || (state == ST_DATA) || (state == ST_CHK);
  assign tmo_clr = rx_new_data || !tmo_en;

  serial_cmd_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .en    (tmo_en),
    .clr   (tmo_clr),
    .expire(tmo_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A timeout always takes priority over a byte landing in the same cycle.
  always_comb begin
    state_nxt = state;
    lat_cmd   = 1'b0;
    lat_data  = 1'b0;
    cap_rd    = 1'b0;
    err_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_new_data && (rx_data == SYNC_BYTE)) state_nxt = ST_CMD;
      end
      ST_CMD: begin
        if (tmo_exp) begin
          err_inc   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (rx_new_data) begin
          lat_cmd = 1'b1;
`ifdef SERIAL_CMD_CHECKSUM_EN
          state_nxt = rx_data[CMD_WR_BIT] ? ST_DATA : ST_CHK;
`else
          state_nxt = rx_data[CMD_WR_BIT] ? ST_DATA : ST_EXEC;
`endif
        end
      end
      ST_DATA: begin
        if (tmo_exp) begin
          err_inc   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (rx_new_data) begin
          lat_data = 1'b1;
`ifdef SERIAL_CMD_CHECKSUM_EN
          state_nxt = ST_CHK;
`else
          state_nxt = ST_EXEC;
`endif
        end
      end
`ifdef SERIAL_CMD_CHECKSUM_EN
      ST_CHK: begin
        if (tmo_exp) begin
          err_inc   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (rx_new_data) begin
          if (rx_data == chk_acc) begin
            state_nxt = ST_EXEC;
          end else begin
            err_inc   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
`endif
      ST_EXEC: begin
        err_inc   = rx_new_data;
        state_nxt = cmd_wr ? ST_IDLE : ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        err_inc   = rx_new_data;
        cap_rd    = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        err_inc = rx_new_data;
        if (!tx_busy) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Without CHK a read can enter EXEC straight from CMD, before cmd_wr is loaded.
  assign wr_nxt = lat_cmd ? rx_data[CMD_WR_BIT] : cmd_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_addr    <= '0;
      reg_wr_data <= '0;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      cmd_wr      <= 1'b0;
      tx_data     <= '0;
      err_cnt     <= '0;
    end else begin
      reg_wr_en <= (state_nxt == ST_EXEC) && (state != ST_EXEC) && wr_nxt;
      reg_rd_en <= (state_nxt == ST_EXEC) && (state != ST_EXEC) && !wr_nxt;
      if (lat_cmd) begin
        reg_addr <= rx_data[CMD_ADDR_MSB:0];
        cmd_wr   <= rx_data[CMD_WR_BIT];
      end
      if (lat_data) reg_wr_data <= rx_data;
      if (cap_rd) tx_data <= reg_rd_data;
      if (err_inc) err_cnt <= err_sat_inc(err_cnt);
    end
  end

`ifdef SERIAL_CMD_CHECKSUM_EN
  // Running XOR seeded with the sync byte while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_acc <= SYNC_BYTE;
    end else if (state == ST_IDLE) begin
      chk_acc <= SYNC_BYTE;
    end else if (lat_cmd || lat_data) begin
      chk_acc <= chk_acc ^ rx_data;
    end
  end
`endif

  assign tx_new_data = (state == ST_RESP) && !tx_busy;

endmodule

// File: tb/tb_serial_cmd_ctrl.sv
// Directed bench for serial_cmd_ctrl: frame table plus timeout, backpressure,
// mid-frame reset and error-counter saturation sequences.
module tb_serial_cmd_ctrl;

`ifdef SERIAL_CMD_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam int         TMO     = 20;
  localparam logic [7:0] BAD_ERR = CHK_EN ? 8'd1 : 8'd0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_new_data = 1'b0;
  logic [3:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rd_data;
  logic [7:0] tx_data;
  logic       tx_new_data;
  logic       tx_busy = 1'b0;
  logic [7:0] err_cnt;

  serial_cmd_ctrl #(.TIMEOUT_CLKS(TMO), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_new_data(rx_new_data),
    .reg_addr   (reg_addr),
    .reg_wr_data(reg_wr_data),
    .reg_wr_en  (reg_wr_en),
    .reg_rd_en  (reg_rd_en),
    .reg_rd_data(reg_rd_data),
    .tx_data    (tx_data),
    .tx_new_data(tx_new_data),
    .tx_busy    (tx_busy),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // Register-file model: read data is only valid the cycle after reg_rd_en.
  logic [7:0] rd_value = '0;
  logic [7:0] rd_q = '0;
  always @(posedge clk) rd_q <= reg_rd_en ? rd_value : 8'h00;
  assign reg_rd_data = rd_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         wr_n = 0, rd_n = 0, tx_n = 0;
  int         wr_cyc = 0, rd_cyc = 0, tx_cyc = 0, rx_cyc = 0;
  logic [3:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_d = '0, tx_d = '0;

  always @(negedge clk) begin
    if (rx_new_data) rx_cyc <= cyc;
    if (reg_wr_en) begin
      wr_n    <= wr_n + 1;
      wr_cyc  <= cyc;
      wr_addr <= reg_addr;
      wr_d    <= reg_wr_data;
    end
    if (reg_rd_en) begin
      rd_n    <= rd_n + 1;
      rd_cyc  <= cyc;
      rd_addr <= reg_addr;
    end
    if (tx_new_data) begin
      tx_n   <= tx_n + 1;
      tx_cyc <= cyc;
      tx_d   <= tx_data;
    end
  end

  int checks = 0;
  int failures = 0;
  int wr0, rd0, tx0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one byte for the current cycle; returns #1 into the following cycle.
  task automatic send_byte(input logic [7:0] b);
    rx_data     = b;
    rx_new_data = 1'b1;
    @(posedge clk);
    #1;
    rx_new_data = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(cmd);
    if (cmd[7]) send_byte(data);
    if (CHK_EN) send_byte(chk);
  endtask

  task automatic snap();
    wr0 = wr_n;
    rd0 = rd_n;
    tx0 = tx_n;
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);
  endtask

  task automatic bad_frame();
    if (CHK_EN) begin
      send_frame(8'h83, 8'h3C, 8'h00);
    end else begin
      send_byte(8'hA5);
      idle(TMO);
    end
  endtask

  typedef struct {
    bit         pre_en;
    logic [7:0] pre;
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] chk;
    logic [7:0] rd_val;
    bit         exp_wr;
    bit         exp_rd;
    logic [3:0] exp_addr;
    logic [7:0] exp_wdata;
    logic [7:0] exp_tx;
    logic [7:0] exp_err;
  } vec_t;

  function automatic vec_t mk(input bit pe, input logic [7:0] pre, input logic [7:0] cmd,
                              input logic [7:0] data, input logic [7:0] chk,
                              input logic [7:0] rdv, input bit ew, input bit er,
                              input logic [3:0] ea, input logic [7:0] ewd,
                              input logic [7:0] etx, input logic [7:0] eerr);
    vec_t v;
    v.pre_en = pe;  v.pre = pre;  v.cmd = cmd;  v.data = data;  v.chk = chk;
    v.rd_val = rdv; v.exp_wr = ew; v.exp_rd = er; v.exp_addr = ea;
    v.exp_wdata = ewd; v.exp_tx = etx; v.exp_err = eerr;
    return v;
  endfunction

  localparam int NV = 7;
  vec_t vecs[NV];
  int   rel_cyc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    //            pre_en pre    cmd    data   chk    rd     wr rd addr  wdata  tx     err
    vecs[0] = mk(1, 8'h3C, 8'h83, 8'h3C, 8'h1A, 8'h00, 1, 0, 4'h3, 8'h3C, 8'h00, 8'd0);
    vecs[1] = mk(0, 8'h00, 8'h03, 8'h00, 8'hA6, 8'h5E, 0, 1, 4'h3, 8'h3C, 8'h5E, 8'd0);
    vecs[2] = mk(0, 8'h00, 8'hF7, 8'h00, 8'h52, 8'h00, 1, 0, 4'h7, 8'h00, 8'h5E, 8'd0);
    vecs[3] = mk(1, 8'h11, 8'h7C, 8'h00, 8'hD9, 8'hC3, 0, 1, 4'hC, 8'h00, 8'hC3, 8'd0);
    vecs[4] = mk(0, 8'h00, 8'h8A, 8'hA5, 8'h8A, 8'h00, 1, 0, 4'hA, 8'hA5, 8'hC3, 8'd0);
    vecs[5] = mk(0, 8'h00, 8'h83, 8'h3C, 8'h00, 8'h00, !CHK_EN, 0, 4'h3, 8'h3C, 8'hC3, BAD_ERR);
    vecs[6] = mk(0, 8'h00, 8'h8F, 8'hFF, 8'hD5, 8'h00, 1, 0, 4'hF, 8'hFF, 8'hC3, BAD_ERR);

    idle(2);
    check("rst_reg_addr", int'(reg_addr), 0);
    check("rst_reg_wr_data", int'(reg_wr_data), 0);
    check("rst_reg_wr_en", int'(reg_wr_en), 0);
    check("rst_reg_rd_en", int'(reg_rd_en), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_tx_new_data", int'(tx_new_data), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    rst = 1'b1;
    idle(2);

    for (int i = 0; i < NV; i++) begin
      rd_value = vecs[i].rd_val;
      snap();
      if (vecs[i].pre_en) begin
        send_byte(vecs[i].pre);
        idle(1);
      end
      send_frame(vecs[i].cmd, vecs[i].data, vecs[i].chk);
      idle(6);
      check($sformatf("v%0d_wr_cnt", i), wr_n - wr0, int'(vecs[i].exp_wr));
      check($sformatf("v%0d_rd_cnt", i), rd_n - rd0, int'(vecs[i].exp_rd));
      check($sformatf("v%0d_tx_cnt", i), tx_n - tx0, int'(vecs[i].exp_rd));
      check($sformatf("v%0d_reg_addr", i), int'(reg_addr), int'(vecs[i].exp_addr));
      check($sformatf("v%0d_reg_wr_data", i), int'(reg_wr_data), int'(vecs[i].exp_wdata));
      check($sformatf("v%0d_tx_data", i), int'(tx_data), int'(vecs[i].exp_tx));
      check($sformatf("v%0d_err_cnt", i), int'(err_cnt), int'(vecs[i].exp_err));
      if (vecs[i].exp_wr) begin
        check($sformatf("v%0d_wr_addr", i), int'(wr_addr), int'(vecs[i].exp_addr));
        check($sformatf("v%0d_wr_data", i), int'(wr_d), int'(vecs[i].exp_wdata));
        check($sformatf("v%0d_wr_latency", i), wr_cyc - rx_cyc, 1);
      end
      if (vecs[i].exp_rd) begin
        check($sformatf("v%0d_rd_addr", i), int'(rd_addr), int'(vecs[i].exp_addr));
        check($sformatf("v%0d_rd_latency", i), rd_cyc - rx_cyc, 1);
        check($sformatf("v%0d_tx_after_rd", i), tx_cyc - rd_cyc, 2);
        check($sformatf("v%0d_tx_strobe_data", i), int'(tx_d), int'(vecs[i].exp_tx));
      end
    end

    // Last byte one cycle before expiry is still accepted.
    do_reset();
    snap();
    send_byte(8'hA5);
    send_byte(8'h83);
    idle(TMO - 2);
    send_byte(8'h3C);
    if (CHK_EN) send_byte(8'h1A);
    idle(4);
    check("tmo_edge_wr_cnt", wr_n - wr0, 1);
    check("tmo_edge_err", int'(err_cnt), 0);

    // Byte landing on the expiry cycle loses; frame dropped and counted once.
    do_reset();
    snap();
    send_byte(8'hA5);
    send_byte(8'h83);
    idle(TMO - 1);
    send_byte(8'h3C);
    check("tmo_err", int'(err_cnt), 1);
    if (CHK_EN) send_byte(8'h1A);
    idle(4);
    check("tmo_late_wr_cnt", wr_n - wr0, 0);
    check("tmo_late_err", int'(err_cnt), 1);

    // Byte arriving in EXEC is dropped and counted; the write still happens.
    do_reset();
    snap();
    send_frame(8'h85, 8'h42, 8'h62);
    send_byte(8'h77);
    idle(4);
    check("exec_drop_wr_cnt", wr_n - wr0, 1);
    check("exec_drop_wr_data", int'(wr_d), 8'h42);
    check("exec_drop_err", int'(err_cnt), 1);

    // Response backpressure with an extra byte while waiting.
    do_reset();
    tx_busy  = 1'b1;
    rd_value = 8'h5E;
    snap();
    send_frame(8'h03, 8'h00, 8'hA6);
    idle(40);
    send_byte(8'h55);
    idle(59);
    check("bp_no_tx_while_busy", tx_n - tx0, 0);
    check("bp_tx_data_held", int'(tx_data), 8'h5E);
    check("bp_err", int'(err_cnt), 1);
    tx_busy = 1'b0;
    rel_cyc = cyc;
    idle(3);
    check("bp_tx_cnt", tx_n - tx0, 1);
    check("bp_tx_cycle", tx_cyc - rel_cyc, 0);
    check("bp_tx_strobe_data", int'(tx_d), 8'h5E);

    // Asynchronous reset mid-frame.
    do_reset();
    snap();
    send_byte(8'hA5);
    send_byte(8'h83);
    rst = 1'b0;
    #3;
    check("midrst_reg_addr", int'(reg_addr), 0);
    check("midrst_strobes", int'({reg_wr_en, reg_rd_en, tx_new_data}), 0);
    check("midrst_err", int'(err_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_byte(8'h3C);
    send_byte(8'h1A);
    idle(4);
    check("midrst_no_wr", wr_n - wr0, 0);
    check("midrst_reg_addr_after", int'(reg_addr), 0);
    check("midrst_err_after", int'(err_cnt), 0);

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      bad_frame();
      if (i == 253) check("sat_err_254", int'(err_cnt), 8'hFE);
      if (i == 254) check("sat_err_255", int'(err_cnt), 8'hFF);
    end
    check("sat_err_300", int'(err_cnt), 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
